// File: rtl/sweep_sequencer.sv
// ============================================================================
//  Module   : sweep_sequencer
//  Brief    : Stepped-frequency sweep controller: DDS write, settle, measure,
//             and stream out one tagged amplitude/phase result per point.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sweep_sequencer #(
   parameter int FWORD_W  = 32,
   parameter int RES_W    = 32,
   parameter int CNT_W    = 16,
   parameter int SETTLE_W = 24,
   parameter int TIMEOUT  = 1 << 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [FWORD_W-1:0]  cfg_start_fword,
   input  logic [FWORD_W-1:0]  cfg_step_fword,
   input  logic [CNT_W-1:0]    cfg_points,
   input  logic [SETTLE_W-1:0] cfg_settle,
   output logic [FWORD_W-1:0]  dds_fword,
   output logic                dds_wen,
   output logic                meas_start,
   input  logic                meas_done,
   input  logic [RES_W-1:0]    meas_amp,
   input  logic [RES_W-1:0]    meas_phase,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [CNT_W-1:0]    res_index,
   output logic [FWORD_W-1:0]  res_fword,
   output logic [RES_W-1:0]    res_amp,
   output logic [RES_W-1:0]    res_phase,
   output logic                res_err,
   output logic                busy,
   output logic                done
);

   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_MEAS   = 3'd3,
      S_WAIT   = 3'd4,
      S_OUT    = 3'd5
   } state_t;

   state_t              state;
   logic [FWORD_W-1:0]  fword;
   logic [FWORD_W-1:0]  step;
   logic [CNT_W-1:0]    index;
   logic [CNT_W-1:0]    points;
   logic [SETTLE_W-1:0] settle;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [TO_W-1:0]     to_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         fword      <= '0;
         step       <= '0;
         index      <= '0;
         points     <= '0;
         settle     <= '0;
         settle_cnt <= '0;
         to_cnt     <= '0;
         dds_fword  <= '0;
         dds_wen    <= 1'b0;
         meas_start <= 1'b0;
         res_valid  <= 1'b0;
         res_index  <= '0;
         res_fword  <= '0;
         res_amp    <= '0;
         res_phase  <= '0;
         res_err    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         // Strobes default low; each is raised only on the transition that owns it.
         dds_wen    <= 1'b0;
         meas_start <= 1'b0;
         done       <= 1'b0;
         if (abort) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     if (cfg_points != '0) begin
                        fword     <= cfg_start_fword;
                        step      <= cfg_step_fword;
                        points    <= cfg_points;
                        settle    <= cfg_settle;
                        index     <= '0;
                        dds_fword <= cfg_start_fword;
                        dds_wen   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                     end else begin
                        done <= 1'b1;
                     end
                  end
               end
               S_LOAD: begin
                  settle_cnt <= settle;
                  state      <= S_SETTLE;
               end
               S_SETTLE: begin
                  if (settle_cnt == '0) begin
                     meas_start <= 1'b1;
                     state      <= S_MEAS;
                  end else begin
                     settle_cnt <= settle_cnt - 1'b1;
                  end
               end
               S_MEAS: begin
                  to_cnt <= '0;
                  state  <= S_WAIT;
               end
               S_WAIT: begin
                  // A completion in the final timeout cycle still wins.
                  if (meas_done) begin
                     res_amp   <= meas_amp;
                     res_phase <= meas_phase;
                     res_err   <= 1'b0;
                     res_index <= index;
                     res_fword <= fword;
                     res_valid <= 1'b1;
                     state     <= S_OUT;
                  end else if (to_cnt == TO_LAST) begin
                     res_amp   <= '0;
                     res_phase <= '0;
                     res_err   <= 1'b1;
                     res_index <= index;
                     res_fword <= fword;
                     res_valid <= 1'b1;
                     state     <= S_OUT;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end
               S_OUT: begin
                  if (res_ready) begin
                     res_valid <= 1'b0;
                     if (index == points - 1'b1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                     end else begin
                        fword     <= fword + step;
                        index     <= index + 1'b1;
                        dds_fword <= fword + step;
                        dds_wen   <= 1'b1;
                        state     <= S_LOAD;
                     end
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sweep_sequencer.sv
// ============================================================================
//  Module   : tb_sweep_sequencer
//  Brief    : Directed bench with an event-level reference model of the sweep.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sweep_sequencer;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst, start, abort, res_ready, meas_done;
   logic [31:0] cfg_start_fword, cfg_step_fword, meas_amp, meas_phase;
   logic [15:0] cfg_points;
   logic [23:0] cfg_settle;
   logic [31:0] dds_fword, res_fword, res_amp, res_phase;
   logic [15:0] res_index;
   logic        dds_wen, meas_start, res_valid, res_err, busy, done;

   int tests = 0;
   int fails = 0;
   int t = 0;
   int late_at = -1;
   bit resp_en = 1'b1;

   sweep_sequencer #(.FWORD_W(32), .RES_W(32), .CNT_W(16), .SETTLE_W(24), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_start_fword(cfg_start_fword), .cfg_step_fword(cfg_step_fword),
      .cfg_points(cfg_points), .cfg_settle(cfg_settle),
      .dds_fword(dds_fword), .dds_wen(dds_wen), .meas_start(meas_start),
      .meas_done(meas_done), .meas_amp(meas_amp), .meas_phase(meas_phase),
      .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
      .res_fword(res_fword), .res_amp(res_amp), .res_phase(res_phase),
      .res_err(res_err), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @t=%0d: got %h expected %h", name, t, act, exp);
      end
   endtask

   // Observation logs
   int          wen_t[$], ms_t[$], hs_t[$], rv_t[$], hs_idx[$];
   logic [31:0] wen_fw[$], hs_amp[$];
   logic        hs_err[$];
   int          done_cnt = 0;
   logic        prev_rv = 1'b0;

   // Reference model: events scheduled in absolute cycle numbers
   bit          m_busy, m_valid, m_wait, was_busy;
   int          m_points, m_settle, m_idx, wait_from;
   int          exp_wen, exp_ms, exp_done;
   logic [31:0] m_start, m_step, e_dds, e_fw, e_amp, e_phase;
   int          e_index;
   logic        e_err;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_busy = 0; m_valid = 0; m_wait = 0; m_idx = 0;
            exp_wen = -1; exp_ms = -1; exp_done = -1; e_dds = '0;
            prev_rv = 1'b0;
         end else begin
            chk("dds_wen", dds_wen, t == exp_wen);
            chk("dds_fword", dds_fword, e_dds);
            chk("meas_start", meas_start, t == exp_ms);
            chk("done", done, t == exp_done);
            chk("busy", busy, m_busy);
            chk("res_valid", res_valid, m_valid);
            if (m_valid) begin
               chk("res_index", res_index, e_index);
               chk("res_fword", res_fword, e_fw);
               chk("res_amp", res_amp, e_amp);
               chk("res_phase", res_phase, e_phase);
               chk("res_err", res_err, e_err);
            end

            if (dds_wen) begin wen_t.push_back(t); wen_fw.push_back(dds_fword); end
            if (meas_start) ms_t.push_back(t);
            if (done) done_cnt++;
            if (res_valid && !prev_rv) rv_t.push_back(t);
            prev_rv = res_valid;
            if (res_valid && res_ready && !abort) begin
               hs_t.push_back(t); hs_idx.push_back(int'(res_index));
               hs_err.push_back(res_err); hs_amp.push_back(res_amp);
            end

            was_busy = m_busy;
            if (abort) begin
               m_busy = 0; m_valid = 0; m_wait = 0;
               exp_wen = -1; exp_ms = -1; exp_done = -1;
            end else begin
               if (m_valid && res_ready) begin
                  m_valid = 0;
                  if (m_idx == m_points - 1) begin
                     exp_done = t + 1;
                     m_busy = 0;
                  end else begin
                     m_idx++;
                     e_dds = m_start + m_step * 32'(m_idx);
                     exp_wen = t + 1;
                     exp_ms = t + m_settle + 3;
                  end
               end
               if (m_busy && t == exp_ms) begin
                  m_wait = 1;
                  wait_from = t + 1;
               end else if (m_wait && t >= wait_from) begin
                  if (meas_done) begin
                     m_wait = 0; m_valid = 1; e_err = 0;
                     e_amp = meas_amp; e_phase = meas_phase;
                  end else if (t == wait_from + TO - 1) begin
                     m_wait = 0; m_valid = 1; e_err = 1;
                     e_amp = '0; e_phase = '0;
                  end
                  if (m_valid) begin
                     e_index = m_idx;
                     e_fw = m_start + m_step * 32'(m_idx);
                  end
               end
               if (!was_busy && start) begin
                  if (cfg_points != 0) begin
                     m_busy = 1; m_idx = 0;
                     m_start = cfg_start_fword; m_step = cfg_step_fword;
                     m_points = int'(cfg_points); m_settle = int'(cfg_settle);
                     e_dds = cfg_start_fword;
                     exp_wen = t + 1;
                     exp_ms = t + m_settle + 3;
                  end else begin
                     exp_done = t + 1;
                  end
               end
            end
         end
         t++;
      end
   end

   // Measurement detector stand-in: answers 5 cycles after meas_start
   initial begin
      int md_cnt;
      md_cnt = 0;
      meas_done = 0; meas_amp = '0; meas_phase = '0;
      forever begin
         @(posedge clk); #2;
         meas_done = 0;
         if (md_cnt > 0) begin
            md_cnt--;
            if (md_cnt == 0) begin
               meas_done = 1; meas_amp = $urandom; meas_phase = $urandom;
            end
         end
         if (t == late_at) begin
            meas_done = 1; meas_amp = $urandom; meas_phase = $urandom;
         end
         if (meas_start && resp_en && !rst) md_cnt = 5;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #2;
      end
   endtask

   task automatic do_start();
      start = 1; tick(1); start = 0;
   endtask

   task automatic set_cfg(input logic [31:0] sf, input logic [31:0] st,
                          input logic [15:0] pts, input logic [23:0] sett);
      cfg_start_fword = sf; cfg_step_fword = st; cfg_points = pts; cfg_settle = sett;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((busy || res_valid) && n < budget) begin tick(1); n++; end
      tests++;
      if (busy) begin
         fails++;
         $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
      end
      tick(2);
   endtask

   initial begin
      int b, mb, hb, rb, d0, n, ts;
      rst = 1; start = 0; abort = 0; res_ready = 1;
      set_cfg(32'h0, 32'h0, 16'd0, 24'd0);
      tick(3);
      chk("reset_busy", busy, 0);
      chk("reset_fword", dds_fword, 0);
      chk("reset_valid", res_valid, 0);
      chk("reset_done", done, 0);
      rst = 0;
      tick(2);

      // Basic three-point sweep
      set_cfg(32'h1000, 32'h0100, 16'd3, 24'd4);
      b = wen_t.size(); mb = ms_t.size(); hb = hs_t.size(); d0 = done_cnt;
      ts = t;
      do_start();
      wait_idle("basic", 400);
      chk("basic_wen_cnt", wen_t.size() - b, 3);
      chk("basic_first_wen_lat", wen_t[b] - ts, 1);
      chk("basic_first_ms_lat", ms_t[mb] - ts, 7);
      chk("basic_fw0", wen_fw[b], 32'h1000);
      chk("basic_fw1", wen_fw[b+1], 32'h1100);
      chk("basic_fw2", wen_fw[b+2], 32'h1200);
      for (int i = 0; i < 3; i++) chk("basic_wen_to_ms", ms_t[mb+i] - wen_t[b+i], 6);
      for (int i = 0; i < 3; i++) chk("basic_res_idx", hs_idx[hb+i], i);
      chk("basic_done_cnt", done_cnt - d0, 1);

      // Backpressure at point 1, plus ignored start and cfg change mid-sweep
      res_ready = 0;
      b = wen_t.size();
      do_start();
      tick(3);
      set_cfg(32'hDEAD0000, 32'h5555, 16'd7, 24'd1);
      do_start();
      n = 0; while (!res_valid && n < 200) begin tick(1); n++; end
      chk("bp_valid0", res_valid, 1);
      res_ready = 1; tick(1); res_ready = 0;
      n = 0; while (!res_valid && n < 200) begin tick(1); n++; end
      chk("bp_valid1", res_valid, 1);
      mb = wen_t.size();
      tick(20);
      chk("bp_no_wen", wen_t.size(), mb);
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_idx", res_index, 1);
      chk("bp_hold_fw", res_fword, 32'h1100);
      res_ready = 1;
      wait_idle("backpressure", 400);
      chk("bp_wen_cnt", wen_t.size() - b, 3);
      chk("bp_fw2", wen_fw[b+2], 32'h1200);

      // Wrap of the frequency word and zero settle
      set_cfg(32'hFFFFFF80, 32'h100, 16'd2, 24'd0);
      b = wen_t.size(); mb = ms_t.size();
      do_start();
      wait_idle("wrap", 300);
      chk("wrap_fw1", wen_fw[b+1], 32'h00000080);
      chk("wrap_settle0", ms_t[mb] - wen_t[b], 2);
      chk("wrap_settle1", ms_t[mb+1] - wen_t[b+1], 2);

      // Timeout on every point
      resp_en = 0;
      set_cfg(32'h3000, 32'h10, 16'd2, 24'd1);
      mb = ms_t.size(); hb = hs_t.size(); rb = rv_t.size();
      do_start();
      wait_idle("timeout", 600);
      chk("to_latency", rv_t[rb] - ms_t[mb], TO + 1);
      chk("to_err0", hs_err[hb], 1);
      chk("to_err1", hs_err[hb+1], 1);
      chk("to_amp0", hs_amp[hb], 0);
      chk("to_idx1", hs_idx[hb+1], 1);
      resp_en = 1;

      // Abort in SETTLE of point 1, followed by a stray meas_done
      set_cfg(32'h2000, 32'h10, 16'd3, 24'd10);
      b = wen_t.size(); mb = ms_t.size(); d0 = done_cnt;
      do_start();
      n = 0; while (wen_t.size() < b + 2 && n < 300) begin tick(1); n++; end
      chk("abort_reach_p1", wen_t.size() - b, 2);
      tick(2);
      abort = 1; tick(1); abort = 0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", res_valid, 0);
      late_at = t + 2;
      tick(10);
      chk("abort_no_done", done_cnt, d0);
      chk("abort_still_idle", busy, 0);
      chk("abort_ms_cnt", ms_t.size() - mb, 1);
      set_cfg(32'h2000, 32'h10, 16'd2, 24'd2);
      b = wen_t.size(); hb = hs_t.size();
      do_start();
      wait_idle("restart", 300);
      chk("restart_fw0", wen_fw[b], 32'h2000);
      chk("restart_idx0", hs_idx[hb], 0);
      chk("restart_idx1", hs_idx[hb+1], 1);

      // Zero-point start
      set_cfg(32'h4000, 32'h10, 16'd0, 24'd2);
      b = wen_t.size(); d0 = done_cnt;
      do_start();
      tick(3);
      chk("zero_done", done_cnt - d0, 1);
      chk("zero_no_wen", wen_t.size(), b);
      chk("zero_busy", busy, 0);

      // Reset while waiting for a measurement
      resp_en = 0;
      set_cfg(32'h5000, 32'h10, 16'd1, 24'd2);
      mb = ms_t.size();
      do_start();
      n = 0; while (ms_t.size() == mb && n < 100) begin tick(1); n++; end
      tick(5);
      chk("pre_rst_busy", busy, 1);
      #1 rst = 1;
      #1;
      chk("rst_ctrl", {dds_wen, meas_start, res_valid, res_err, busy, done}, 0);
      chk("rst_fword", dds_fword, 0);
      chk("rst_res", {res_amp, res_phase}, 0);
      chk("rst_idx", {res_index, res_fword}, 0);
      tick(2);
      rst = 0;
      resp_en = 1;
      tick(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, t=%0d", t);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
